// File: rtl/axi_memory_slave_burst.sv
// rtl/axi_memory_slave_burst.sv - AXI4 burst memory responder with independent read/write FSMs
// Define AXI_SLAVE_WSTRB_EN to make writes honour wstrb byte lanes; otherwise every beat writes the full word.
module axi_memory_slave_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_err_q, w_err_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]            r_burst_q, r_burst_d;

    logic w_in_range, w_beat_last, r_in_range, r_beat_last;
    logic unused_ok;

    // INCR and WRAP both step by one word; FIXED and the reserved code hold.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst);
        return (burst == 2'b01 || burst == 2'b10) ? addr + ADDR_WIDTH'(1) : addr;
    endfunction

    assign w_in_range  = (w_addr_q < DEPTH_A);
    assign w_beat_last = (w_cnt_q == w_len_q);
    assign r_in_range  = (r_addr_q < DEPTH_A);
    assign r_beat_last = (r_cnt_q == r_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = RESP_OKAY;
        if (resetn) begin
            case (w_state_q)
                W_IDLE: begin
                    awready = 1'b1;
                    if (awvalid) begin
                        w_id_d    = awid;
                        w_addr_d  = awaddr;
                        w_len_d   = awlen;
                        w_burst_d = awburst;
                        w_cnt_d   = '0;
                        w_err_d   = 1'b0;
                        w_state_d = W_DATA;
                    end
                end
                W_DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        w_err_d  = w_err_q | ~w_in_range | (wlast != w_beat_last);
                        w_addr_d = next_addr(w_addr_q, w_burst_q);
                        w_cnt_d  = w_cnt_q + 8'd1;
                        if (w_beat_last) w_state_d = W_RESP;
                    end
                end
                W_RESP: begin
                    bvalid = 1'b1;
                    bid    = w_id_q;
                    bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
                    if (bready) w_state_d = W_IDLE;
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = RESP_OKAY;
        rlast     = 1'b0;
        if (resetn) begin
            case (r_state_q)
                R_IDLE: begin
                    arready = 1'b1;
                    if (arvalid) begin
                        r_id_d    = arid;
                        r_addr_d  = araddr;
                        r_len_d   = arlen;
                        r_burst_d = arburst;
                        r_cnt_d   = '0;
                        r_state_d = R_DATA;
                    end
                end
                R_DATA: begin
                    rvalid = 1'b1;
                    rid    = r_id_q;
                    rdata  = r_in_range ? mem_q[r_addr_q[IDX_W-1:0]] : '0;
                    rresp  = r_in_range ? RESP_OKAY : RESP_SLVERR;
                    rlast  = r_beat_last;
                    if (rready) begin
                        r_addr_d = next_addr(r_addr_q, r_burst_q);
                        r_cnt_d  = r_cnt_q + 8'd1;
                        if (r_beat_last) r_state_d = R_IDLE;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
        end
    end

    // Storage is deliberately left out of reset; wready is already low while resetn is low.
    always_ff @(posedge clk) begin
        if (wready && wvalid && w_in_range) begin
`ifdef AXI_SLAVE_WSTRB_EN
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem_q[w_addr_q[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
`else
            mem_q[w_addr_q[IDX_W-1:0]] <= wdata;
`endif
        end
    end

`ifdef AXI_SLAVE_WSTRB_EN
    assign unused_ok = ^{awsize, arsize};
`else
    assign unused_ok = ^{awsize, arsize, wstrb};
`endif

endmodule

// File: tb/tb_axi_memory_slave_burst.sv
// tb/tb_axi_memory_slave_burst.sv - scoreboard bench for axi_memory_slave_burst against a word-array reference model
module tb_axi_memory_slave_burst;
    localparam int AW = 32, DW = 32, IW = 4, DEPTH = 1024;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [IW-1:0] awid = '0, arid = '0, bid, rid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [2:0]    awsize = 3'd2, arsize = 3'd2;
    logic [1:0]    awburst = 2'b01, arburst = 2'b01, bresp, rresp;
    logic          awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic          bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic          rlast, rvalid, rready = 1'b0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [3:0]    wstrb = 4'hF;

    always #5 clk = ~clk;

    axi_memory_slave_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;

    int            n_vec = 0, n_err = 0;
    logic [DW-1:0] model [DEPTH];
    r_exp_t        rq[$];
    b_exp_t        bq[$];
    logic [DW-1:0] wdq[$];
    logic [3:0]    wsq[$];
    bit            rnd_strb = 1'b0;
    logic [63:0]   aw_t = '0, ar_t = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [1:0] burst, input int k);
        return (burst == 2'b01 || burst == 2'b10) ? base + AW'(k) : base;
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            0: return awready;
            1: return wready;
            default: return arready;
        endcase
    endfunction

    task automatic wait_rdy(input int sel, input string name, output int waited);
        waited = 0;
        @(negedge clk);
        while (!rdy(sel) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy(sel)) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: ready=0 required=1", name);
        end
    endtask

    // Monitor: pops expectations on every handshake and checks stall stability.
    logic        prev_r_stall = 1'b0, prev_b_stall = 1'b0;
    logic [63:0] prev_r = '0, prev_b = '0;
    always @(negedge clk) begin
        r_exp_t re;
        b_exp_t be;
        if (resetn) begin
            if (prev_r_stall) begin
                check("r_stall_valid", 64'(rvalid), 64'd1);
                check("r_stall_hold", {23'd0, rid, rresp, rlast, rdata}, prev_r);
            end
            if (prev_b_stall) begin
                check("b_stall_valid", 64'(bvalid), 64'd1);
                check("b_stall_hold", {58'd0, bid, bresp}, prev_b);
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL r_unexpected: rvalid beat rdata=0x%0h with no expected beat", rdata);
                end else begin
                    re = rq.pop_front();
                    check("rdata", 64'(rdata), 64'(re.data));
                    check("rresp", 64'(rresp), 64'(re.resp));
                    check("rlast", 64'(rlast), 64'(re.last));
                    check("rid", 64'(rid), 64'(re.id));
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected: bvalid with bid=%0d and no expected response", bid);
                end else begin
                    be = bq.pop_front();
                    check("bresp", 64'(bresp), 64'(be.resp));
                    check("bid", 64'(bid), 64'(be.id));
                end
            end
            prev_r_stall = rvalid && !rready;
            prev_r       = {23'd0, rid, rresp, rlast, rdata};
            prev_b_stall = bvalid && !bready;
            prev_b       = {58'd0, bid, bresp};
        end else begin
            prev_r_stall = 1'b0;
            prev_b_stall = 1'b0;
        end
    end

    // bad_wlast: 1 = drop wlast on final beat, 2 = raise wlast on beat 0 of a longer burst.
    task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                               input logic [1:0] burst, input int bad_wlast, input int bhold,
                               input int abort_after);
        logic          err;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    s;
        int            waited;
        err = 1'b0;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        wait_rdy(0, "awready", waited);
        check("awready_idle_wait", 64'(waited), 64'd0);
        aw_t = $time;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            d = (wdq.size() != 0) ? wdq.pop_front() : $urandom;
            s = (wsq.size() != 0) ? wsq.pop_front() : (rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
            a = beat_addr(addr, burst, k);
            wdata = d; wstrb = s; wvalid = 1'b1;
            wlast = (k == len);
            if (bad_wlast == 1 && k == len) wlast = 1'b0;
            if (bad_wlast == 2 && k == 0 && len > 0) wlast = 1'b1;
            if (wlast != (k == len)) err = 1'b1;
            wait_rdy(1, "wready", waited);
            check("wready_per_cycle", 64'(waited), 64'd0);
            if (a < AW'(DEPTH)) begin
`ifdef AXI_SLAVE_WSTRB_EN
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[a[9:0]][b*8 +: 8] = d[b*8 +: 8];
`else
                model[a[9:0]] = d;
`endif
            end else begin
                err = 1'b1;
            end
            @(posedge clk); #1;
            if (abort_after == k + 1) begin
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        @(negedge clk);
        check("bvalid_after_last_w", 64'(bvalid), 64'd1);
        repeat (bhold) begin
            @(negedge clk);
            check("bvalid_held", 64'(bvalid), 64'd1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", 64'(awready), 64'd1);
        @(posedge clk); #1;
    endtask

    // mode: 0 = rready always 1, 1 = random, 2 = repeating 1,0,0,1
    task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                              input logic [1:0] burst, input int mode);
        logic [AW-1:0] a;
        int            waited, got, cyc;
        bit            done;
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, burst, k);
            rq.push_back('{id: id,
                           data: (a < AW'(DEPTH)) ? model[a[9:0]] : '0,
                           resp: (a < AW'(DEPTH)) ? 2'b00 : 2'b10,
                           last: (k == len)});
        end
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        wait_rdy(2, "arready", waited);
        check("arready_idle_wait", 64'(waited), 64'd0);
        ar_t = $time;
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 4000) begin
            case (mode)
                0: rready = 1'b1;
                1: rready = 1'($urandom_range(0, 1));
                default: rready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(negedge clk);
            if (cyc == 0) check("rvalid_after_ar", 64'(rvalid), 64'd1);
            if (rvalid && rready) begin
                got++;
                if (rlast) done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beat_count", 64'(got), 64'(len + 1));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {14'd0, awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp}, 64'd0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 5) == 0) return AW'(DEPTH - $urandom_range(1, 6));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_outputs_zero");
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("awready_after_reset", 64'(awready), 64'd1);
        check("arready_after_reset", 64'(arready), 64'd1);
        @(posedge clk); #1;

        // Fill the whole array with maximum-length bursts so every later read is defined.
        for (int i = 0; i < DEPTH / 256; i++)
            write_burst(4'(i), AW'(i * 256), 255, 2'b01, 0, 0, 0);

        wdq.push_back(32'hDEADBEEF);
        write_burst(4'd3, 32'd5, 0, 2'b01, 0, 0, 0);
        read_burst(4'd3, 32'd5, 0, 2'b01, 0);

        for (int i = 1; i <= 4; i++) wdq.push_back(DW'(i));
        write_burst(4'd1, 32'h10, 3, 2'b01, 0, 5, 0);
        read_burst(4'd2, 32'h10, 3, 2'b01, 0);
        read_burst(4'd4, 32'h10, 3, 2'b01, 2);

        write_burst(4'd6, AW'(DEPTH - 1), 1, 2'b01, 0, 0, 0);
        read_burst(4'd6, AW'(DEPTH - 1), 1, 2'b01, 0);
        read_burst(4'd7, 32'hFFFF_FFFE, 3, 2'b01, 1);

        wdq.push_back(32'h11223344); wsq.push_back(4'hF);
        write_burst(4'd8, 32'd7, 0, 2'b01, 0, 0, 0);
        wdq.push_back(32'hAABBCCDD); wsq.push_back(4'b0011);
        write_burst(4'd8, 32'd7, 0, 2'b01, 0, 0, 0);
        read_burst(4'd8, 32'd7, 0, 2'b01, 0);

        write_burst(4'd9, 32'd40, 2, 2'b01, 1, 0, 0);
        write_burst(4'd10, 32'd50, 3, 2'b01, 2, 0, 0);
        write_burst(4'd11, 32'd60, 3, 2'b00, 0, 1, 0);
        read_burst(4'd11, 32'd60, 2, 2'b00, 1);

        write_burst(4'd12, 32'd200, 3, 2'b01, 0, 0, 2);
        resetn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_mid_burst_outputs_zero");
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("awready_after_mid_reset", 64'(awready), 64'd1);
        check("arready_after_mid_reset", 64'(arready), 64'd1);
        check("no_bvalid_after_mid_reset", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        read_burst(4'd12, 32'd200, 3, 2'b01, 0);

        fork
            write_burst(4'd13, 32'd300, 3, 2'b01, 0, 0, 0);
            read_burst(4'd14, 32'd400, 3, 2'b10, 1);
        join
        check("aw_ar_same_cycle", aw_t, ar_t);

        rnd_strb = 1'b1;
        for (int i = 0; i < 25; i++) begin
            write_burst(4'($urandom), rnd_addr(), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(0, 3), 0);
            read_burst(4'($urandom), rnd_addr(), $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1);
        end

        repeat (3) @(negedge clk);
        check("r_queue_drained", 64'(rq.size()), 64'd0);
        check("b_queue_drained", 64'(bq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
